// File: rtl/full_adder_8bit.sv
// full_adder_8bit: 8-bit ripple-carry adder built from chained full-adder cells, optional 1-cycle output register.
// Define FULL_ADDER_8BIT_FLAGS_EN to add zero/neg/ovf result flags.
module full_adder_8bit #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] o,
    output logic       cout,
    output logic       out_valid
`ifdef FULL_ADDER_8BIT_FLAGS_EN
    ,
    output logic       zero,
    output logic       neg,
    output logic       ovf
`endif
);
`ifdef FULL_ADDER_8BIT_FLAGS_EN
    localparam int W = 12;
`else
    localparam int W = 9;
`endif
    logic [8:0]   c;
    logic [7:0]   s;
    logic [W-1:0] res;
    logic [W-1:0] res_out;
    assign c[0] = c_in;
    for (genvar i = 0; i < 8; i++) begin : g_cell
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    // Flags ride in the same word as sum/carry so they share timing and reset.
`ifdef FULL_ADDER_8BIT_FLAGS_EN
    assign res = {c[7] ^ c[8], s[7], s == 8'h00, c[8], s};
`else
    assign res = {c[8], s};
`endif
    if (OUT_REG) begin : g_reg
        logic [W-1:0] res_d, res_q;
        logic         valid_d, valid_q;
        always_comb begin
            res_d   = in_valid ? res : res_q;
            valid_d = in_valid;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                res_q   <= res_d;
                valid_q <= valid_d;
            end
        end
        assign res_out   = res_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign res_out   = res;
        assign out_valid = in_valid;
    end
    assign {cout, o} = res_out[8:0];
`ifdef FULL_ADDER_8BIT_FLAGS_EN
    assign {ovf, neg, zero} = res_out[11:9];
`endif
endmodule

// File: tb/tb_full_adder_8bit.sv
// tb_full_adder_8bit: randomized and directed checks of full_adder_8bit (OUT_REG=1) against an arithmetic model.
module tb_full_adder_8bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;
    logic       c_in = 1'b0;
    logic [7:0] o;
    logic       cout;
    logic       out_valid;
`ifdef FULL_ADDER_8BIT_FLAGS_EN
    logic       zero, neg, ovf;
`endif
    int total = 0;
    int bad = 0;

    full_adder_8bit #(.OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .c_in(c_in),
        .o(o), .cout(cout), .out_valid(out_valid)
`ifdef FULL_ADDER_8BIT_FLAGS_EN
        , .zero(zero), .neg(neg), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int t;
        t = int'(a) + int'(b) + int'(ci);
        return t[8:0];
    endfunction

    function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int t;
        t = int'($signed(a)) + int'($signed(b)) + int'(ci);
        return (t > 127) || (t < -128);
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        in_valid = v;
        x = a;
        y = b;
        c_in = ci;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, cout, o} !== 10'h000) begin
            bad++;
            $display("FAIL reset: out_valid=%b cout=%b o=%h want 0 0 00", out_valid, cout, o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, cout, o} !== 10'h000) begin
            bad++;
            $display("FAIL idle: out_valid=%b cout=%b o=%h want 0 0 00", out_valid, cout, o);
        end
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        total++;
        if ({out_valid, cout, o} !== 10'h200) begin
            bad++;
            $display("FAIL zero_add: out_valid=%b cout=%b o=%h want 1 0 00", out_valid, cout, o);
        end
    endtask

    task automatic test_directed;
        logic [7:0] va [5] = '{8'h45, 8'hFF, 8'h7F, 8'hFF, 8'h00};
        logic [7:0] vb [5] = '{8'h2A, 8'h00, 8'h01, 8'hFF, 8'h00};
        logic       vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] ve [5] = '{9'h06F, 9'h100, 9'h080, 9'h1FF, 9'h000};
        logic [2:0] vf [5] = '{3'b000, 3'b001, 3'b110, 3'b010, 3'b001};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, va[k], vb[k], vc[k]);
            @(negedge clk);
            total++;
            if ({out_valid, cout, o} !== {1'b1, ve[k]}) begin
                bad++;
                $display("FAIL directed%0d: out_valid=%b cout=%b o=%h want 1 %b %h", k, out_valid, cout, o, ve[k][8], ve[k][7:0]);
            end
`ifdef FULL_ADDER_8BIT_FLAGS_EN
            total++;
            if ({ovf, neg, zero} !== vf[k]) begin
                bad++;
                $display("FAIL flags%0d: ovf/neg/zero=%b want %b", k, {ovf, neg, zero}, vf[k]);
            end
`else
            if (vf[k] === 3'bxxx) $display("unused %0d", k);
`endif
        end
    endtask

    task automatic test_random;
        logic [8:0] exp_r = {cout, 8'h00};
        logic [7:0] a, b;
        logic       ci, v;
        exp_r = 9'h000;
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 60; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ci = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            drive(v, a, b, ci);
            if (v) exp_r = model_sum(a, b, ci);
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if ({out_valid, cout, o} !== {v, exp_r}) begin
                bad++;
                $display("FAIL random%0d: out_valid=%b cout=%b o=%h want %b %b %h", k, out_valid, cout, o, v, exp_r[8], exp_r[7:0]);
            end
`ifdef FULL_ADDER_8BIT_FLAGS_EN
            if (v) begin
                total++;
                if ({ovf, neg, zero} !== {model_ovf(a, b, ci), exp_r[7], exp_r[7:0] == 8'h00}) begin
                    bad++;
                    $display("FAIL rflags%0d: ovf/neg/zero=%b", k, {ovf, neg, zero});
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] q[$];
        logic [8:0] e;
        logic [8:0] last = 9'h000;
        for (int i = 0; i <= 128; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q.pop_front();
                last = e;
                total++;
                if ({out_valid, cout, o} !== {1'b1, e}) begin
                    bad++;
                    $display("FAIL b2b%0d: out_valid=%b cout=%b o=%h want 1 %b %h", i - 1, out_valid, cout, o, e[8], e[7:0]);
                end
            end
            if (i < 128) begin
                in_valid = 1'b1;
                x = 8'(i);
                y = 8'(2 * i + 1);
                c_in = 1'b0;
                q.push_back(model_sum(8'(i), 8'(2 * i + 1), 1'b0));
            end else begin
                in_valid = 1'b0;
            end
        end
        x = 8'h11;
        y = 8'h22;
        @(negedge clk);
        total++;
        if ({out_valid, cout, o} !== {1'b0, last}) begin
            bad++;
            $display("FAIL hold: out_valid=%b cout=%b o=%h want 0 %b %h", out_valid, cout, o, last[8], last[7:0]);
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 8'hC0, 8'h50, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, cout, o} !== 10'h000) begin
            bad++;
            $display("FAIL async_rst: out_valid=%b cout=%b o=%h want 0 0 00", out_valid, cout, o);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, cout, o} !== 10'h000) begin
            bad++;
            $display("FAIL rst_held: out_valid=%b cout=%b o=%h want 0 0 00", out_valid, cout, o);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, cout, o} !== 10'h000) begin
            bad++;
            $display("FAIL post_rst: out_valid=%b cout=%b o=%h want 0 0 00", out_valid, cout, o);
        end
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, cout, o} !== 10'h230) begin
            bad++;
            $display("FAIL first_after_rst: out_valid=%b cout=%b o=%h want 1 0 30", out_valid, cout, o);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/full_adder_8bit.md
Name: full_adder_8bit

Overview:
- 8-bit ripple-carry adder datapath element for the 8-bit processor ALU.
- Adds operands x and y plus carry-in c_in, and produces the 8-bit sum o and carry-out cout.
- Built from eight chained 1-bit full-adder cells, with optional output registering on the single system clock.
- Asynchronous active-low reset.

Parameters:
- OUT_REG, default 1: 1 = sum/carry/valid registered (1-cycle latency); 0 = purely combinational outputs, registers unused.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  operands on x/y/c_in are valid this cycle
- x  input  8  operand A, unsigned/two's complement
- y  input  8  operand B
- c_in  input  1  carry into bit 0
- o  output  8  sum bits [7:0]
- cout  output  1  carry out of bit 7
- out_valid  output  1  o/cout hold a result

Behaviour:
- Cell i (i=0..7):
  - s_i = x_i ^ y_i ^ c_i
  - c_{i+1} = (x_i & y_i) | (c_i & (x_i ^ y_i))
  - c_0 = c_in; cout = c_8.
- Arithmetic: {cout, o} = x + y + c_in, exact, 9-bit result; no saturation. Wrap-around is modulo 256, with the carry reported on cout.
- OUT_REG=1:
  - On rising clk with in_valid=1: o, cout load the combinational result; out_valid <= 1.
  - On rising clk with in_valid=0: o, cout hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle. There is no backpressure.
- OUT_REG=0:
  - o/cout follow the inputs combinationally.
  - out_valid = in_valid.
  - rst_n affects only optional registered state.
- Reset (rst_n=0, asynchronous, any time, including mid-stream):
  - o=8'h00, cout=0, out_valid=0 immediately.
  - Any in-flight result is discarded.
  - The first capture is on the first rising clk after rst_n deasserts.
- Inputs carrying X/Z are not supported. Unknown inputs may propagate to outputs.
- Boundaries:
  - 8'hFF+8'h00+1 -> o=8'h00, cout=1.
  - 8'hFF+8'hFF+1 -> o=8'hFF, cout=1.
  - 0+0+0 -> o=0, cout=0.

Optional Feature:
- Macro FULL_ADDER_8BIT_FLAGS_EN.
- When defined, adds three outputs with the same timing and reset (0) as o:
  - zero (1 when o==0)
  - neg (o[7])
  - ovf (signed overflow = c_7 ^ c_8)
- When undefined, these ports and their logic do not exist. Core behaviour is identical in both cases.

Test Plan:
- Reset then idle, with x=y=0 and c_in=0 -> o=8'h00, cout=0, out_valid=0. After one in_valid cycle -> o=00, cout=0.
- x=8'h45, y=8'h2A, c_in=0, in_valid=1 -> next cycle o=8'h6F, cout=0, out_valid=1. With flags: zero=0, neg=0, ovf=0.
- x=8'hFF, y=8'h00, c_in=1 -> o=8'h00, cout=1. With flags: zero=1, ovf=0.
- x=8'h7F, y=8'h01, c_in=0 -> o=8'h80, cout=0. With flags: neg=1, ovf=1.
- Back-to-back stream x=i, y=2i+1 for i=0..127 (results mod 256) -> each result one cycle later, out_valid held high. Then drop in_valid -> out_valid=0 and o holds its last value.
- Assert rst_n=0 mid-stream, between clock edges -> outputs go to 0 without waiting for a clock edge. After release, the first result appears one cycle after the next valid input.
